// File: rtl/picomem_stream_writer_if.sv
// Stream-in and PicoMem native bus signals of the stream writer.
// master is the writer's view; slave is the byte source plus memory responder.
interface picomem_stream_writer_if;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic        mem_m_valid;
  logic        mem_m_ready;
  logic [31:0] mem_m_addr;
  logic [31:0] mem_m_wdata;
  logic [3:0]  mem_m_wstrb;

  modport master (
    input  s_valid, s_data, s_last, mem_m_ready,
    output s_ready, mem_m_valid, mem_m_addr, mem_m_wdata, mem_m_wstrb
  );

  modport slave (
    output s_valid, s_data, s_last, mem_m_ready,
    input  s_ready, mem_m_valid, mem_m_addr, mem_m_wdata, mem_m_wstrb
  );
endinterface

// File: rtl/picomem_stream_writer.sv
// Packs a byte stream little-endian into 32-bit words and writes them to
// consecutive word addresses of a PicoMem responder.
module picomem_stream_writer #(
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic [31:0]            start_addr,
  picomem_stream_writer_if.master bus,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       word_count
);

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  lane;
  logic        last_flag;
  logic        valid_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        done_q;
  logic [CNT_W-1:0] count_q;

  logic accept, word_full, write_done, start_ok;

  // done shares its cycle with IDLE, yet start is still ignored there
  assign start_ok   = (state == IDLE) && start && !done_q;
  assign accept     = (state == FILL) && bus.s_valid;
  assign word_full  = accept && ((lane == 2'd3) || bus.s_last);
  assign write_done = (state == WRITE) && bus.mem_m_ready;

  assign bus.s_ready     = (state == FILL);
  assign busy            = (state != IDLE);
  assign bus.mem_m_valid = valid_q;
  assign bus.mem_m_addr  = addr_q;
  assign bus.mem_m_wdata = wdata_q;
  assign bus.mem_m_wstrb = wstrb_q;
  assign done            = done_q;
  assign word_count      = count_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = FILL;
      FILL:    if (word_full) state_nxt = WRITE;
      WRITE:   if (bus.mem_m_ready) state_nxt = last_flag ? IDLE : FILL;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      lane      <= '0;
      last_flag <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      // valid follows the next state so it drops on the ready edge itself
      valid_q <= (state_nxt == WRITE);
      done_q  <= write_done && last_flag;
      if (start_ok) begin
        addr_q  <= {start_addr[31:2], 2'b00};
        lane    <= '0;
        wdata_q <= '0;
        wstrb_q <= '0;
        count_q <= '0;
      end
      if (accept) begin
        wdata_q[8*lane +: 8] <= bus.s_data;
        wstrb_q[lane]        <= 1'b1;
        lane                 <= lane + 2'd1;
        last_flag            <= bus.s_last;
      end
      if (write_done) begin
        addr_q  <= addr_q + 32'd4;
        count_q <= count_q + CNT_W'(1);
        wdata_q <= '0;
        wstrb_q <= '0;
        lane    <= '0;
      end
    end
  end

endmodule
